// File: rtl/alu_share_arbiter_if.sv
// Request/response and ALU-path bundle shared by the two requesters, the
// arbiter and the ALU datapath.
interface alu_share_arbiter_if #(parameter int W = 32);
   logic [1:0]   req;
   logic [3:0]   op0, op1;
   logic [W-1:0] a0, b0, a1, b1;
   logic [1:0]   gnt;
   logic [1:0]   done;
   logic [W-1:0] result;
   logic [3:0]   flags;
   logic         wb;
   logic         err;
   logic [W-1:0] aluA, aluB;
   logic [3:0]   aluOp;
   logic         aluValid;
   logic [W-1:0] aluResult;
   logic [3:0]   aluFlags;

   modport slave (
      input  req, op0, op1, a0, b0, a1, b1, aluResult, aluFlags,
      output gnt, done, result, flags, wb, err, aluA, aluB, aluOp, aluValid
   );

   modport master (
      output req, op0, op1, a0, b0, a1, b1, aluResult, aluFlags,
      input  gnt, done, result, flags, wb, err, aluA, aluB, aluOp, aluValid
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters: grant in IDLE,
// one EXEC cycle on the ALU, one RESP cycle returning result/NZCV.
module alu_share_arbiter #(parameter int W = 32) (
   input logic               clk,
   input logic               rst,
   alu_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t       state, state_nx;
   logic         prio, port, sel, pend_wb;
   logic [3:0]   sel_op, dec_op;
   logic         dec_wb, dec_rej;
   logic [W-1:0] sel_a, sel_b;
   logic [1:0]   gnt_c, done_c;
   logic         valid_c;
   logic [W-1:0] result_q, alua_q, alub_q;
   logic [3:0]   flags_q, aluop_q;
   logic         wb_q, err_q;

   // Contention goes to the favoured port; otherwise whoever is asking.
   assign sel    = (bus.req == 2'b11) ? prio : bus.req[1];
   assign sel_op = sel ? bus.op1 : bus.op0;
   assign sel_a  = sel ? bus.a1  : bus.a0;
   assign sel_b  = sel ? bus.b1  : bus.b0;

   always_comb begin
      dec_op  = sel_op;
      dec_wb  = 1'b1;
      dec_rej = 1'b0;
      case (sel_op)
         4'd8:  begin dec_op = 4'd0; dec_wb = 1'b0; end
         4'd9:  begin dec_op = 4'd1; dec_wb = 1'b0; end
         4'd10: begin dec_op = 4'd2; dec_wb = 1'b0; end
         4'd11: begin dec_op = 4'd4; dec_wb = 1'b0; end
         4'd14: begin dec_rej = 1'b1; dec_wb = 1'b0; end
         default: ;
      endcase
   end

   always_comb begin
      state_nx = state;
      gnt_c    = 2'b00;
      done_c   = 2'b00;
      valid_c  = 1'b0;
      case (state)
         IDLE: if (|bus.req) begin
            gnt_c[sel] = 1'b1;
            state_nx   = dec_rej ? RESP : EXEC;
         end
         EXEC: begin
            valid_c  = 1'b1;
            state_nx = RESP;
         end
         RESP: begin
            done_c[port] = 1'b1;
            state_nx     = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Strobes stay quiet while reset is held so an aborted op never completes.
      if (!rst) begin
         gnt_c   = 2'b00;
         done_c  = 2'b00;
         valid_c = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         prio     <= 1'b0;
         port     <= 1'b0;
         pend_wb  <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
         wb_q     <= 1'b0;
         err_q    <= 1'b0;
         alua_q   <= '0;
         alub_q   <= '0;
         aluop_q  <= '0;
      end else begin
         state <= state_nx;
         if (gnt_c != 2'b00) begin
            port <= sel;
            // Rejected ops skip the ALU; their response is known at grant.
            if (dec_rej) begin
               result_q <= '0;
               flags_q  <= '0;
               wb_q     <= 1'b0;
               err_q    <= 1'b1;
            end else begin
               alua_q  <= sel_a;
               alub_q  <= sel_b;
               aluop_q <= dec_op;
               pend_wb <= dec_wb;
            end
         end
         if (state == EXEC) begin
            result_q <= bus.aluResult;
            flags_q  <= bus.aluFlags;
            wb_q     <= pend_wb;
            err_q    <= 1'b0;
         end
         if (state == RESP) prio <= ~port;
      end
   end

   assign bus.gnt      = gnt_c;
   assign bus.done     = done_c;
   assign bus.aluValid = valid_c;
   assign bus.result   = result_q;
   assign bus.flags    = flags_q;
   assign bus.wb       = wb_q;
   assign bus.err      = err_q;
   assign bus.aluA     = alua_q;
   assign bus.aluB     = alub_q;
   assign bus.aluOp    = aluop_q;
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-port arbiter and sequencer that shares the single ALU datapath between the CPU execute stage (port 0) and the image-decryption coprocessor (port 1). It accepts one ARM data-processing request at a time, with round-robin fairness. It drives the ARM opcode and operands into the ALU path (opcode-to-ALU-control translation sits downstream), then captures the result and NZCV flags and returns them to the winning requester with a done pulse. Compare-class opcodes are rewritten and flagged as no-writeback; unsupported opcodes are rejected without touching the ALU.

## Interface
- W, 32, operand/result width
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- req  in  2  request per port, held until matching gnt
- op0, op1  in  4  ARM opcode per port (bits 24:21 encoding)
- a0, b0, a1, b1  in  W  operands per port
- gnt  out  2  one-hot accept strobe; operands are captured on the edge where gnt is high
- done  out  2  one-hot, one-cycle completion strobe
- result  out  W  completion result, valid with done
- flags  out  4  NZCV from ALU, valid with done
- wb  out  1  1 = result must be written back; 0 = flags-only op
- err  out  1  1 = opcode rejected
- aluA, aluB  out  W  ALU operands
- aluOp  out  4  ARM opcode to the ALU path
- aluValid  out  1  ALU inputs valid this cycle
- aluResult  in  W  ALU result, combinational from aluA/aluB/aluOp
- aluFlags  in  4  ALU NZCV, combinational

## Operation
- FSM states: IDLE, EXEC, RESP. Round-robin pointer `prio` (1 bit) names the favoured port.
- **IDLE**
  - If exactly one req bit is set, grant that port.
  - If both are set, grant port `prio`.
  - gnt is combinational, high only in IDLE.
  - At the granting edge, latch the port id, opcode and operands.
  - Next state is EXEC for supported or compare ops, RESP for rejected ops.
- **Opcode classes, decided at grant**
  - Supported 0–7, 12, 13, 15: aluOp = op, wb = 1.
  - Compare ops are rewritten and set wb = 0: 8 (TST) -> 0, 9 (TEQ) -> 1, 10 (CMP) -> 2, 11 (CMN) -> 4.
  - 14 (BIC) is rejected: err = 1, wb = 0, result = 0, flags = 0, and no ALU issue.
- **EXEC** (one cycle)
  - Drive aluA/aluB/aluOp from the latched registers with aluValid = 1.
  - Capture aluResult/aluFlags at the end of the cycle.
  - Next state is RESP.
- **RESP** (one cycle)
  - done[port] = 1; result, flags, wb and err come from registers.
  - `prio` <= ~port.
  - Next state is IDLE.
- req seen in EXEC or RESP is ignored; no gnt outside IDLE.
- A requester may deassert req before gnt with no effect. After gnt it must not re-raise req until its done.
- Outside EXEC: aluValid = 0 and aluA/aluB/aluOp hold their last values. Outside RESP: done = 0; result/flags/wb/err hold.

## Timing
- Reset values: state IDLE, prio 0, gnt 0, done 0, aluValid 0, result 0, flags 0, wb 0, err 0, aluA 0, aluB 0, aluOp 0.
- Reset asserted mid-operation aborts the op: no done, pending op dropped, everything returns to reset values.
- Supported op with grant at edge N:
  - aluValid high in cycle N+1.
  - done high in cycle N+2.
  - IDLE in cycle N+3, so a new grant is possible at edge N+3.
- Rejected op with grant at edge N: done in cycle N+1, no aluValid.
- Throughput: one op per 3 cycles; 2 cycles for rejected ops.
- Requests are not starved: with both ports requesting continuously, grants alternate 0, 1, 0, 1 …

## Test plan
- **Reset:** hold rst = 0 for 3 cycles with req = 2'b11 -> all outputs 0, no gnt. After release, first grant goes to port 0.
- **Single ADD:** port 0, op = 4, a0 = 5, b0 = 7 ->
  - gnt[0] at N.
  - aluValid with aluOp = 4 at N+1.
  - done[0] at N+2 with result = 12, wb = 1, err = 0.
- **Contention:** both ports held requesting, op0 = 2 (SUB 9−3), op1 = 0 (AND 0xF0 & 0x3C) ->
  - grants in order port 0, then port 1 (3 cycles later), then port 0.
  - results 6 and 0x30 reach the correct done bits.
- **Compare:** port 1, op = 10 (CMP 3, 3) -> aluOp = 2, done[1] with flags Z = 1, wb = 0.
- **Reject:** port 0, op = 14 ->
  - done[0] one cycle after gnt, err = 1, result = 0.
  - aluValid never asserted.
  - prio flips to 1.
- **Mid-op reset:** rst low during EXEC -> no done pulse. Next cycle after release is IDLE with prio = 0.
